// File: rtl/fetch_const_assembler.sv
// Displacement/immediate assembler for one x86-64 instruction: little-endian byte collection with running extension.
// Optional abort input enabled by the FETCH_CONST_FLUSH_EN macro.
module fetch_const_assembler #(
    parameter int MQ_N   = 4,
    parameter int IMM_W  = 64,
    parameter int DISP_W = 32
) (
    input  logic              clk,
    input  logic              rst,
`ifdef FETCH_CONST_FLUSH_EN
    input  logic              flush,
`endif
    input  logic              start,
    output logic              start_ready,
    input  logic [2:0]        disp_size,
    input  logic [3:0]        imm_size,
    input  logic              imm_sext,
    input  logic [MQ_N-1:0]   imm_to_in,
    input  logic [MQ_N-1:0]   disp_to_in,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [IMM_W-1:0]  imm,
    output logic [DISP_W-1:0] disp,
    output logic [MQ_N-1:0]   imm_to,
    output logic [MQ_N-1:0]   disp_to,
    output logic              size_err
);
    localparam int IMM_MAX  = IMM_W / 8;
    localparam int DISP_MAX = DISP_W / 8;

    typedef enum logic [1:0] {S_IDLE, S_DISP, S_IMM, S_HOLD} state_t;

    state_t             state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic [2:0]         disp_sz_q, disp_sz_d;
    logic [3:0]         imm_sz_q, imm_sz_d;
    logic               sext_q, sext_d;
    logic [IMM_W-1:0]   imm_q, imm_d;
    logic [DISP_W-1:0]  disp_q, disp_d;
    logic [MQ_N-1:0]    imm_to_q, imm_to_d;
    logic [MQ_N-1:0]    disp_to_q, disp_to_d;
    logic               err_q, err_d;

    logic [2:0]         disp_sz_c;
    logic [3:0]         imm_sz_c;
    logic               disp_over, imm_over;
    logic [IMM_W-1:0]   disp_wide;

    // Writes byte k and floods every higher byte with the extension bit,
    // so the field is valid as an extended value after each byte.
    function automatic logic [IMM_W-1:0] place_byte(input logic [IMM_W-1:0] old,
                                                    input logic [3:0] k,
                                                    input logic [7:0] b,
                                                    input logic ext);
        logic [IMM_W-1:0] r;
        r = '0;
        for (int j = 0; j < IMM_W / 8; j++) begin
            if (j < int'(k))       r[8*j +: 8] = old[8*j +: 8];
            else if (j == int'(k)) r[8*j +: 8] = b;
            else                   r[8*j +: 8] = {8{ext}};
        end
        return r;
    endfunction

    always_comb begin
        disp_over = (disp_size > 3'(DISP_MAX));
        imm_over  = (imm_size > 4'(IMM_MAX));
        disp_sz_c = disp_over ? 3'(DISP_MAX) : disp_size;
        imm_sz_c  = imm_over ? 4'(IMM_MAX) : imm_size;
        disp_wide = place_byte({{(IMM_W-DISP_W){1'b0}}, disp_q}, cnt_q, byte_data, byte_data[7]);
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        disp_sz_d = disp_sz_q;
        imm_sz_d  = imm_sz_q;
        sext_d    = sext_q;
        imm_d     = imm_q;
        disp_d    = disp_q;
        imm_to_d  = imm_to_q;
        disp_to_d = disp_to_q;
        err_d     = err_q;
        case (state_q)
            S_IDLE: if (start) begin
                disp_sz_d = disp_sz_c;
                imm_sz_d  = imm_sz_c;
                sext_d    = imm_sext;
                imm_to_d  = imm_to_in;
                disp_to_d = disp_to_in;
                err_d     = err_q | disp_over | imm_over;
                imm_d     = '0;
                disp_d    = '0;
                cnt_d     = '0;
                if (disp_sz_c != 3'd0)     state_d = S_DISP;
                else if (imm_sz_c != 4'd0) state_d = S_IMM;
                else                       state_d = S_HOLD;
            end
            S_DISP: if (byte_valid) begin
                disp_d = disp_wide[DISP_W-1:0];
                cnt_d  = cnt_q + 4'd1;
                if (cnt_q == {1'b0, disp_sz_q} - 4'd1) begin
                    cnt_d   = '0;
                    state_d = (imm_sz_q != 4'd0) ? S_IMM : S_HOLD;
                end
            end
            S_IMM: if (byte_valid) begin
                imm_d = place_byte(imm_q, cnt_q, byte_data, sext_q & byte_data[7]);
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == imm_sz_q - 4'd1) state_d = S_HOLD;
            end
            S_HOLD: if (out_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
`ifdef FETCH_CONST_FLUSH_EN
        // Abort beats every handshake, including a coincident start.
        if (flush) begin
            state_d   = S_IDLE;
            cnt_d     = '0;
            imm_d     = '0;
            disp_d    = '0;
            imm_to_d  = '0;
            disp_to_d = '0;
            err_d     = err_q;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            disp_sz_q <= '0;
            imm_sz_q  <= '0;
            sext_q    <= 1'b0;
            imm_q     <= '0;
            disp_q    <= '0;
            imm_to_q  <= '0;
            disp_to_q <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            disp_sz_q <= disp_sz_d;
            imm_sz_q  <= imm_sz_d;
            sext_q    <= sext_d;
            imm_q     <= imm_d;
            disp_q    <= disp_d;
            imm_to_q  <= imm_to_d;
            disp_to_q <= disp_to_d;
            err_q     <= err_d;
        end
    end

    assign start_ready = (state_q == S_IDLE);
    assign byte_ready  = (state_q == S_DISP) || (state_q == S_IMM);
    assign out_valid   = (state_q == S_HOLD);
    assign imm         = imm_q;
    assign disp        = disp_q;
    assign imm_to      = imm_to_q;
    assign disp_to     = disp_to_q;
    assign size_err    = err_q;
endmodule

// File: tb/tb_fetch_const_assembler.sv
// Directed-vector bench for fetch_const_assembler; flush scenario built when FETCH_CONST_FLUSH_EN is defined.
module tb_fetch_const_assembler;
    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        start;
    logic        start_ready;
    logic [2:0]  disp_size;
    logic [3:0]  imm_size;
    logic        imm_sext;
    logic [3:0]  imm_to_in, disp_to_in;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] imm;
    logic [31:0] disp;
    logic [3:0]  imm_to, disp_to;
    logic        size_err;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    fetch_const_assembler dut (
        .clk(clk), .rst(rst),
`ifdef FETCH_CONST_FLUSH_EN
        .flush(flush),
`endif
        .start(start), .start_ready(start_ready),
        .disp_size(disp_size), .imm_size(imm_size), .imm_sext(imm_sext),
        .imm_to_in(imm_to_in), .disp_to_in(disp_to_in),
        .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
        .out_valid(out_valid), .out_ready(out_ready),
        .imm(imm), .disp(disp), .imm_to(imm_to), .disp_to(disp_to),
        .size_err(size_err)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] ds, input logic [3:0] is, input logic sx,
                         input logic [3:0] it, input logic [3:0] dt);
        start = 1'b1; disp_size = ds; imm_size = is; imm_sext = sx;
        imm_to_in = it; disp_to_in = dt;
        step();
        start = 1'b0; imm_to_in = 4'h0; disp_to_in = 4'h0;
    endtask

    task automatic release_hold();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(); step();
        nvec++; if (start_ready !== 1'b1) begin nerr++; $display("FAIL reset_start_ready got %b exp 1", start_ready); end
        nvec++; if (byte_ready !== 1'b0 || out_valid !== 1'b0) begin nerr++; $display("FAIL reset_ready_valid got %b%b exp 00", byte_ready, out_valid); end
        nvec++; if (imm !== 64'h0 || disp !== 32'h0) begin nerr++; $display("FAIL reset_fields got %h/%h exp 0/0", imm, disp); end
        nvec++; if (imm_to !== 4'h0 || disp_to !== 4'h0 || size_err !== 1'b0) begin nerr++; $display("FAIL reset_masks got %h/%h/%b exp 0/0/0", imm_to, disp_to, size_err); end
        rst = 1'b0;
        step();
    endtask

    task automatic test_imm32();
        logic [7:0] b [4];
        int cyc;
        b = '{8'h78, 8'h56, 8'h34, 8'h92};
        issue(3'd0, 4'd4, 1'b1, 4'b0010, 4'b0000);
        cyc = 1;
        nvec++; if (byte_ready !== 1'b1) begin nerr++; $display("FAIL imm32_byte_ready got %b exp 1", byte_ready); end
        for (int i = 0; i < 4; i++) begin
            if (i == 3) begin
                nvec++; if (out_valid !== 1'b0) begin nerr++; $display("FAIL imm32_early_valid got %b exp 0", out_valid); end
            end
            byte_valid = 1'b1; byte_data = b[i];
            step(); cyc++;
        end
        byte_valid = 1'b0;
        nvec++; if (out_valid !== 1'b1 || cyc != 5) begin nerr++; $display("FAIL imm32_latency got valid=%b cyc=%0d exp 1/5", out_valid, cyc); end
        nvec++; if (imm !== 64'hFFFF_FFFF_9234_5678) begin nerr++; $display("FAIL imm32_imm got %h exp ffffffff92345678", imm); end
        nvec++; if (imm_to !== 4'b0010 || disp !== 32'h0) begin nerr++; $display("FAIL imm32_to_disp got %b/%h exp 0010/0", imm_to, disp); end
        release_hold();
        nvec++; if (start_ready !== 1'b1 || out_valid !== 1'b0) begin nerr++; $display("FAIL imm32_release got %b%b exp 10", start_ready, out_valid); end
    endtask

    task automatic test_disp_imm();
        issue(3'd1, 4'd1, 1'b0, 4'b0001, 4'b0100);
        byte_valid = 1'b1; byte_data = 8'hF0;
        step();
        nvec++; if (disp !== 32'hFFFF_FFF0 || byte_ready !== 1'b1) begin nerr++; $display("FAIL dimm_disp_mid got %h/%b exp fffffff0/1", disp, byte_ready); end
        byte_data = 8'h80;
        step();
        byte_valid = 1'b0;
        nvec++; if (out_valid !== 1'b1) begin nerr++; $display("FAIL dimm_latency got %b exp 1", out_valid); end
        nvec++; if (imm !== 64'h80 || disp !== 32'hFFFF_FFF0) begin nerr++; $display("FAIL dimm_fields got %h/%h exp 80/fffffff0", imm, disp); end
        nvec++; if (imm_to !== 4'b0001 || disp_to !== 4'b0100) begin nerr++; $display("FAIL dimm_masks got %b/%b exp 0001/0100", imm_to, disp_to); end
        release_hold();
    endtask

    task automatic test_imm64_bubbles();
        int br_bad;
        br_bad = 0;
        issue(3'd0, 4'd8, 1'b1, 4'b1000, 4'b0000);
        for (int i = 0; i < 8; i++) begin
            byte_valid = 1'b1; byte_data = 8'(i + 1);
            step();
            if (i < 7) begin
                if (byte_ready !== 1'b1) br_bad++;
                byte_valid = 1'b0; byte_data = 8'hEE;
                step();
                if (byte_ready !== 1'b1 || out_valid !== 1'b0) br_bad++;
                if (i == 2) begin
                    nvec++; if (imm !== 64'h0003_0201) begin nerr++; $display("FAIL imm64_partial got %h exp 30201", imm); end
                end
            end
        end
        byte_valid = 1'b0;
        nvec++; if (br_bad != 0) begin nerr++; $display("FAIL imm64_byte_ready got %0d bad cycles exp 0", br_bad); end
        nvec++; if (out_valid !== 1'b1) begin nerr++; $display("FAIL imm64_valid got %b exp 1", out_valid); end
        nvec++; if (imm !== 64'h0807_0605_0403_0201) begin nerr++; $display("FAIL imm64_imm got %h exp 0807060504030201", imm); end
        release_hold();
    endtask

    task automatic test_zero_hold();
        issue(3'd0, 4'd0, 1'b0, 4'b1111, 4'b1010);
        nvec++; if (out_valid !== 1'b1) begin nerr++; $display("FAIL zero_latency got %b exp 1", out_valid); end
        start = 1'b1; disp_size = 3'd2; imm_size = 4'd2; imm_to_in = 4'b0001;
        for (int i = 0; i < 5; i++) begin
            step();
            nvec++;
            if (out_valid !== 1'b1 || start_ready !== 1'b0 || imm !== 64'h0 || imm_to !== 4'b1111 || disp_to !== 4'b1010) begin
                nerr++; $display("FAIL zero_hold_stable got v=%b sr=%b imm=%h to=%b/%b exp 1/0/0/1111/1010", out_valid, start_ready, imm, imm_to, disp_to);
            end
        end
        start = 1'b0; imm_to_in = 4'h0;
        release_hold();
        nvec++; if (start_ready !== 1'b1 || out_valid !== 1'b0) begin nerr++; $display("FAIL zero_release got %b%b exp 10", start_ready, out_valid); end
    endtask

    task automatic test_clamp_rst();
        issue(3'd0, 4'd9, 1'b0, 4'b0100, 4'b0000);
        nvec++; if (size_err !== 1'b1) begin nerr++; $display("FAIL clamp_err got %b exp 1", size_err); end
        for (int i = 0; i < 8; i++) begin
            byte_valid = 1'b1; byte_data = 8'((i + 1) * 17);
            step();
        end
        byte_valid = 1'b0;
        nvec++; if (out_valid !== 1'b1 || imm !== 64'h8877_6655_4433_2211) begin nerr++; $display("FAIL clamp_imm got %b/%h exp 1/8877665544332211", out_valid, imm); end
        release_hold();
        issue(3'd0, 4'd1, 1'b0, 4'b0001, 4'b0000);
        byte_valid = 1'b1; byte_data = 8'h05;
        step();
        byte_valid = 1'b0;
        nvec++; if (imm !== 64'h5 || size_err !== 1'b1) begin nerr++; $display("FAIL clamp_sticky got %h/%b exp 5/1", imm, size_err); end
        release_hold();
        issue(3'd2, 4'd4, 1'b1, 4'b0011, 4'b0110);
        byte_valid = 1'b1; byte_data = 8'hAB;
        step(); step();
        byte_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        nvec++;
        if (start_ready !== 1'b1 || byte_ready !== 1'b0 || out_valid !== 1'b0 || imm !== 64'h0 || disp !== 32'h0 ||
            imm_to !== 4'h0 || disp_to !== 4'h0 || size_err !== 1'b0) begin
            nerr++; $display("FAIL rst_async got sr=%b br=%b v=%b imm=%h disp=%h to=%h/%h err=%b exp 1/0/0/0/0/0/0/0",
                             start_ready, byte_ready, out_valid, imm, disp, imm_to, disp_to, size_err);
        end
        step();
        rst = 1'b0;
        step();
    endtask

`ifdef FETCH_CONST_FLUSH_EN
    task automatic test_flush();
        issue(3'd0, 4'd4, 1'b0, 4'b0010, 4'b0001);
        byte_valid = 1'b1; byte_data = 8'h11;
        step();
        byte_data = 8'h22;
        step();
        byte_data = 8'h33; flush = 1'b1;
        step();
        flush = 1'b0; byte_valid = 1'b0;
        nvec++; if (start_ready !== 1'b1 || imm !== 64'h0 || imm_to !== 4'h0 || disp_to !== 4'h0) begin nerr++; $display("FAIL flush_clear got sr=%b imm=%h to=%h/%h exp 1/0/0/0", start_ready, imm, imm_to, disp_to); end
        step();
        nvec++; if (out_valid !== 1'b0 || start_ready !== 1'b1) begin nerr++; $display("FAIL flush_no_valid got %b%b exp 01", out_valid, start_ready); end
    endtask
`endif

    initial begin
        rst = 1'b1; flush = 1'b0; start = 1'b0; disp_size = 3'd0; imm_size = 4'd0;
        imm_sext = 1'b0; imm_to_in = 4'h0; disp_to_in = 4'h0;
        byte_valid = 1'b0; byte_data = 8'h00; out_ready = 1'b0;
        test_reset();
        test_imm32();
        test_disp_imm();
        test_imm64_bubbles();
        test_zero_hold();
        test_clamp_rst();
`ifdef FETCH_CONST_FLUSH_EN
        test_flush();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
